// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding, sizes and candidate indices for the vote tally slice
package vote_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RELEASE, CLOSED} state_t;
    localparam int NUM_CAND = 4;
    localparam int DEF_CNT_W = 8;
    localparam int CAND1 = 0;
    localparam int CAND2 = 1;
    localparam int CAND3 = 2;
    localparam int CAND4 = 3;
    function automatic logic [1:0] onehot_idx(input logic [NUM_CAND-1:0] v);
        return v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable one-hot hold detection
// The hold count saturates above HOLD_CYCLES, so a button held across sessions never votes twice.
module btn_debounce import vote_pkg::*; #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CAND-1:0] btn,
    output logic [NUM_CAND-1:0] bs,
    output logic                acc,
    output logic [NUM_CAND-1:0] acc_bit,
    output logic                multi
);
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES + 1);
    logic [NUM_CAND-1:0] s1, prev;
    logic [HW-1:0] cnt, hold;
    logic onehot, many, many_q;
    assign onehot = $countones(bs) == 1;
    assign many = $countones(bs) > 1;
    assign hold = !onehot ? '0 : bs != prev ? HW'(1) : cnt == HMAX ? cnt : cnt + HW'(1);
    assign acc = onehot && hold == HW'(HOLD_CYCLES);
    assign acc_bit = bs;
    assign multi = many && !many_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            bs <= '0;
            prev <= '0;
            cnt <= '0;
            many_q <= 1'b0;
        end else begin
            s1 <= btn;
            bs <= s1;
            prev <= bs;
            cnt <= hold;
            many_q <= many;
        end
    end
endmodule

// File: rtl/vote_tally.sv
// vote_tally: session-authorised, debounced, saturating four-candidate vote counter
// Optional VOTE_TIMEOUT_EN adds a session timeout and the timeout pulse output.
module vote_tally import vote_pkg::*; #(
    parameter int HOLD_CYCLES = 4,
`ifdef VOTE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1000,
`endif
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                voter_en,
    input  logic                close_poll,
    input  logic [NUM_CAND-1:0] btn,
    output logic [CNT_W-1:0]    cand1,
    output logic [CNT_W-1:0]    cand2,
    output logic [CNT_W-1:0]    cand3,
    output logic [CNT_W-1:0]    cand4,
    output logic                armed,
    output logic                vote_ack,
    output logic                multi_err,
    output logic                sat,
`ifdef VOTE_TIMEOUT_EN
    output logic                timeout,
`endif
    output logic                closed
);
    state_t state;
    logic [CNT_W-1:0] cnt [NUM_CAND];
    logic [NUM_CAND-1:0] bs, acc_bit;
    logic acc, multi;
    logic [1:0] idx;
`ifdef VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif
    btn_debounce #(.HOLD_CYCLES(HOLD_CYCLES)) u_deb (
        .clk(clk), .rst_n(rst_n), .btn(btn), .bs(bs),
        .acc(acc), .acc_bit(acc_bit), .multi(multi)
    );
    assign idx = onehot_idx(acc_bit);
    assign cand1 = cnt[CAND1];
    assign cand2 = cnt[CAND2];
    assign cand3 = cnt[CAND3];
    assign cand4 = cnt[CAND4];
    assign armed = state == ARMED;
    assign closed = state == CLOSED;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '{default: '0};
            vote_ack <= 1'b0;
            multi_err <= 1'b0;
            sat <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            tcnt <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            vote_ack <= 1'b0;
            multi_err <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (close_poll) state <= CLOSED;
                    else if (voter_en) state <= ARMED;
`ifdef VOTE_TIMEOUT_EN
                    tcnt <= '0;
`endif
                end
                ARMED: begin
`ifdef VOTE_TIMEOUT_EN
                    tcnt <= tcnt + TW'(1);
`endif
                    if (close_poll) state <= CLOSED;
                    else if (acc) begin
                        vote_ack <= 1'b1;
                        state <= RELEASE;
                        // a full count holds and flags saturation instead of wrapping
                        if (cnt[idx] == '1) sat <= 1'b1;
                        else cnt[idx] <= cnt[idx] + 1'b1;
                    end
`ifdef VOTE_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= IDLE;
                        timeout <= 1'b1;
                    end
`endif
                    else multi_err <= multi;
                end
                RELEASE: begin
                    if (close_poll) state <= CLOSED;
                    else if (bs == '0) state <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed self-checking bench for vote_tally with HOLD_CYCLES=4, CNT_W=8
module tb_vote_tally;
    logic clk = 0, rst_n = 0, voter_en = 0, close_poll = 0;
    logic [3:0] btn = 0;
    logic [7:0] cand1, cand2, cand3, cand4;
    logic armed, vote_ack, multi_err, sat, closed;
`ifdef VOTE_TIMEOUT_EN
    logic timeout;
`endif
    int total = 0, bad = 0, acks = 0, mults = 0, a0, m0;

    vote_tally #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .voter_en(voter_en), .close_poll(close_poll), .btn(btn),
        .cand1(cand1), .cand2(cand2), .cand3(cand3), .cand4(cand4),
        .armed(armed), .vote_ack(vote_ack), .multi_err(multi_err), .sat(sat),
`ifdef VOTE_TIMEOUT_EN
        .timeout(timeout),
`endif
        .closed(closed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vote_ack === 1'b1) acks++;
        if (multi_err === 1'b1) mults++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        voter_en = 1;
        step(1);
        voter_en = 0;
    endtask

    task automatic vote(input logic [3:0] b);
        arm();
        btn = b;
        step(8);
        btn = 0;
        step(4);
    endtask

    initial begin
        step(3);
        chk("rst_counts", {cand1, cand2, cand3, cand4}, 0);
        chk("rst_flags", {armed, vote_ack, multi_err, sat, closed}, 0);
        rst_n = 1;
        step(1);

        // basic vote on cand2: ack 6 cycles after the press
        arm();
        chk("basic_armed", armed, 1);
        btn = 4'b0010;
        step(5);
        chk("basic_early_ack", vote_ack, 0);
        step(1);
        chk("basic_ack", vote_ack, 1);
        chk("basic_cand2", cand2, 1);
        step(1);
        chk("basic_ack_pulse", vote_ack, 0);
        step(1);
        btn = 0;
        step(4);
        chk("basic_acks", acks, 1);
        chk("basic_others", {cand1, cand3, cand4}, 0);

        // bouncing press on cand1
        arm();
        a0 = acks;
        btn = 4'b0001; step(1);
        btn = 4'b0000; step(1);
        btn = 4'b0001; step(4);
        chk("bounce_no_early_ack", acks - a0, 0);
        step(5);
        btn = 0;
        step(4);
        chk("bounce_one_ack", acks - a0, 1);
        chk("bounce_cand1", cand1, 1);

        // held button without a session, then into a session
        a0 = acks;
        btn = 4'b0100;
        step(20);
        chk("nosess_cand3", cand3, 0);
        arm();
        step(10);
        chk("held_cand3", cand3, 0);
        chk("held_armed", armed, 1);
        chk("held_acks", acks - a0, 0);
        btn = 0;
        step(3);
        btn = 4'b0100;
        step(8);
        btn = 0;
        step(4);
        chk("release_cand3", cand3, 1);

        // multi-press then a clean cand4 vote
        arm();
        m0 = mults;
        btn = 4'b0011;
        step(6);
        chk("multi_once", mults - m0, 1);
        chk("multi_armed", armed, 1);
        chk("multi_no_count", {cand1, cand2, cand3, cand4}, 32'h01010100);
        btn = 4'b1000;
        step(8);
        btn = 0;
        step(4);
        chk("multi_cand4", cand4, 1);

        // saturate cand1
        repeat (254) vote(4'b0001);
        chk("sat_pre_cand1", cand1, 255);
        chk("sat_pre_flag", sat, 0);
        a0 = acks;
        vote(4'b0001);
        chk("sat_ack", acks - a0, 1);
        chk("sat_cand1", cand1, 255);
        chk("sat_flag", sat, 1);

        // close poll discards the pending session and freezes counts
        arm();
        close_poll = 1;
        step(1);
        close_poll = 0;
        chk("close_closed", closed, 1);
        chk("close_armed", armed, 0);
        a0 = acks;
        arm();
        btn = 4'b0010;
        step(10);
        btn = 0;
        step(3);
        chk("closed_acks", acks - a0, 0);
        chk("closed_cand2", cand2, 1);
        chk("closed_stays", closed, 1);
        rst_n = 0;
        step(1);
        rst_n = 1;
        chk("reset_counts", {cand1, cand2, cand3, cand4}, 0);
        chk("reset_flags", {closed, sat, armed}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
